// File: rtl/vx_cache_flush_ctrl.sv
// vx_cache_flush_ctrl: drains core traffic, then starts flushes on the selected cache units
// and returns one response once every selected unit has reported completion.
module vx_cache_flush_ctrl #(
  parameter int NUM_CACHES = 2,
  parameter int NUM_INPUTS = 2,
  parameter int PARALLEL   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_req_valid,
  output logic                  flush_req_ready,
  input  logic [NUM_CACHES-1:0] flush_req_mask,
  output logic                  flush_rsp_valid,
  input  logic                  flush_rsp_ready,
  input  logic [NUM_INPUTS-1:0] core_req_pending,
  output logic                  core_gate,
  output logic [NUM_CACHES-1:0] cache_flush_valid,
  input  logic [NUM_CACHES-1:0] cache_flush_ready,
  input  logic [NUM_CACHES-1:0] cache_flush_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  flush_count
);
  typedef enum logic [2:0] {IDLE, DRAIN, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [NUM_CACHES-1:0] issue_pend_q, issue_pend_d, wait_pend_q, wait_pend_d, issue_sel, issue_hs;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
  logic core_gate_q, core_gate_d, init_q;
  // sequential mode offers only the lowest pending unit
  assign issue_sel = PARALLEL != 0 ? issue_pend_q : issue_pend_q & (~issue_pend_q + NUM_CACHES'(1));
  assign cache_flush_valid = state_q == ISSUE ? issue_sel : '0;
  assign issue_hs = cache_flush_valid & cache_flush_ready;
  assign flush_req_ready = init_q && state_q == IDLE;
  assign flush_rsp_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign core_gate = core_gate_q;
  assign flush_count = flush_count_q;
  always_comb begin
    state_d = state_q;
    issue_pend_d = issue_pend_q;
    wait_pend_d = wait_pend_q;
    core_gate_d = core_gate_q;
    flush_count_d = flush_count_q;
    case (state_q)
      IDLE: if (flush_req_valid && flush_req_ready) begin
        issue_pend_d = flush_req_mask;
        wait_pend_d = '0;
        core_gate_d = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: if (core_req_pending == '0) state_d = issue_pend_q == '0 ? RESP : ISSUE;
      ISSUE: begin
        // a done arriving with its own start handshake never enters wait_pend
        issue_pend_d = issue_pend_q & ~issue_hs;
        wait_pend_d = (wait_pend_q | issue_hs) & ~cache_flush_done;
        if (PARALLEL != 0 ? issue_pend_d == '0 : issue_hs != '0) state_d = WAIT;
      end
      WAIT: begin
        wait_pend_d = wait_pend_q & ~cache_flush_done;
        if (wait_pend_d == '0) state_d = issue_pend_q != '0 ? ISSUE : RESP;
      end
      RESP: if (flush_rsp_ready) begin
        flush_count_d = flush_count_q + CNT_WIDTH'(1);
        core_gate_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      issue_pend_q <= '0;
      wait_pend_q <= '0;
      core_gate_q <= 1'b0;
      flush_count_q <= '0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_pend_q <= issue_pend_d;
      wait_pend_q <= wait_pend_d;
      core_gate_q <= core_gate_d;
      flush_count_q <= flush_count_d;
      init_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
// tb_vx_cache_flush_ctrl: scoreboard bench for sequential and parallel flush sequencing.
module tb_vx_cache_flush_ctrl;
  localparam int NC = 2;
  localparam int NI = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, gate, busy;
  logic [NC-1:0] mask = '0, cfv, c_ready = '1, c_done, man_done = '0;
  logic [NI-1:0] pend = '0;
  logic [1:0] cnt;
  int lag = 1;
  logic [3:0][NC-1:0] hs_pipe;
  logic p_req_valid = 1'b0, p_req_ready, p_rsp_valid, p_rsp_ready = 1'b1, p_gate, p_busy;
  logic [NC-1:0] p_mask = '0, p_cfv, p_c_ready = 2'b01, p_c_done = '0;
  logic [NI-1:0] p_pend = '0;
  logic [15:0] p_cnt;
  int n_checks = 0, n_fail = 0;
  logic [NC-1:0] exp_iss[$], obs_iss[$];
  int t_iss[$];
  logic [1:0] exp_cnt[$];
  logic [1:0] model_cnt = 2'd0;
  int t_rsp, rsp_cycles, gate_lo, rdy_hi;
  logic gate_after, rdy_after;
  logic [1:0] cnt_after;
  always @(posedge clk) hs_pipe <= reset ? {hs_pipe[2:0], cfv & c_ready} : '0;
  assign c_done = man_done | (lag == 0 ? cfv & c_ready : lag == 1 ? hs_pipe[0] : lag == 2 ? hs_pipe[1] : hs_pipe[2]);
  vx_cache_flush_ctrl #(.NUM_CACHES(NC), .NUM_INPUTS(NI), .PARALLEL(0), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .flush_req_valid(req_valid), .flush_req_ready(req_ready),
    .flush_req_mask(mask), .flush_rsp_valid(rsp_valid), .flush_rsp_ready(rsp_ready),
    .core_req_pending(pend), .core_gate(gate), .cache_flush_valid(cfv),
    .cache_flush_ready(c_ready), .cache_flush_done(c_done), .busy(busy), .flush_count(cnt));
  vx_cache_flush_ctrl #(.NUM_CACHES(NC), .NUM_INPUTS(NI), .PARALLEL(1), .CNT_WIDTH(16)) dut_p (
    .clk(clk), .reset(reset), .flush_req_valid(p_req_valid), .flush_req_ready(p_req_ready),
    .flush_req_mask(p_mask), .flush_rsp_valid(p_rsp_valid), .flush_rsp_ready(p_rsp_ready),
    .core_req_pending(p_pend), .core_gate(p_gate), .cache_flush_valid(p_cfv),
    .cache_flush_ready(p_c_ready), .cache_flush_done(p_c_done), .busy(p_busy), .flush_count(p_cnt));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_main(input logic [NC-1:0] m, input int hold, input logic [NI-1:0] pv,
                          input int stall, input int lg, input logic [NC-1:0] stray);
    int c, st;
    bit fin;
    t_iss.delete(); obs_iss.delete();
    t_rsp = -1; rsp_cycles = 0; gate_lo = 0; rdy_hi = 0; st = 0; fin = 0;
    lag = lg; pend = pv; man_done = stray; rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    req_valid = 1'b1; mask = m;
    for (int i = 0; i < NC; i++) if (m[i]) exp_iss.push_back(NC'(1) << i);
    model_cnt = model_cnt + 2'd1;
    exp_cnt.push_back(model_cnt);
    step();
    req_valid = 1'b0; mask = '1;
    c = 1;
    while (c < 80 && !fin) begin
      pend = c > hold ? '0 : pv;
      if ((cfv & c_ready) != '0) begin obs_iss.push_back(cfv & c_ready); t_iss.push_back(c); end
      if (!gate) gate_lo++;
      if (req_ready) rdy_hi++;
      if (rsp_valid) begin
        if (t_rsp < 0) t_rsp = c;
        rsp_cycles++;
        rsp_ready = st >= stall;
        st++;
        fin = rsp_ready;
      end
      step();
      c++;
    end
    gate_after = gate; rdy_after = req_ready; cnt_after = cnt;
    man_done = '0; rsp_ready = 1'b1; pend = '0;
  endtask
  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || gate !== 1'b0 || rsp_valid !== 1'b0 || cfv !== 2'b00 || cnt !== 2'd0)
      begin n_fail++; $display("FAIL reset_state: rdy=%b busy=%b gate=%b rsp=%b cfv=%b cnt=%0d, want all zero", req_ready, busy, gate, rsp_valid, cfv, cnt); end
    step(); step();
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || p_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_early: got %b/%b want 0/0", req_ready, p_req_ready); end
    step();
    n_checks++;
    if (req_ready !== 1'b1 || p_req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_edge: got %b/%b busy %b want 1/1 busy 0", req_ready, p_req_ready, busy); end
  endtask
  task automatic test_basic();
    logic [NC-1:0] e, o;
    int t;
    logic [1:0] ec;
    run_main(2'b01, 0, 2'b00, 0, 1, 2'b00);
    while (exp_iss.size() > 0) begin
      e = exp_iss.pop_front(); o = 'x; t = -1;
      if (obs_iss.size() > 0) begin o = obs_iss.pop_front(); t = t_iss.pop_front(); end
      n_checks++;
      if (o !== e || t != 2) begin n_fail++; $display("FAIL basic_issue: got %b at %0d want %b at 2", o, t, e); end
    end
    n_checks++;
    if (t_rsp != 4 || rsp_cycles != 1 || gate_lo != 0 || rdy_hi != 0 || obs_iss.size() != 0)
      begin n_fail++; $display("FAIL basic_rsp: rsp@%0d x%0d gate_lo %0d rdy_hi %0d extra %0d want rsp@4 x1 0 0 0", t_rsp, rsp_cycles, gate_lo, rdy_hi, obs_iss.size()); end
    ec = exp_cnt.pop_front();
    n_checks++;
    if (cnt_after !== ec || gate_after !== 1'b0 || rdy_after !== 1'b1)
      begin n_fail++; $display("FAIL basic_after: cnt %0d gate %b rdy %b want cnt %0d gate 0 rdy 1", cnt_after, gate_after, rdy_after, ec); end
  endtask
  task automatic test_drain();
    logic [NC-1:0] e, o;
    int t, te;
    int et[$];
    logic [1:0] ec;
    et = '{7, 9};
    run_main(2'b11, 5, 2'b10, 0, 1, 2'b00);
    while (exp_iss.size() > 0) begin
      e = exp_iss.pop_front(); te = et.pop_front(); o = 'x; t = -1;
      if (obs_iss.size() > 0) begin o = obs_iss.pop_front(); t = t_iss.pop_front(); end
      n_checks++;
      if (o !== e || t != te) begin n_fail++; $display("FAIL drain_issue: got %b at %0d want %b at %0d", o, t, e, te); end
    end
    n_checks++;
    if (t_rsp != 11 || gate_lo != 0 || rdy_hi != 0 || obs_iss.size() != 0)
      begin n_fail++; $display("FAIL drain_rsp: rsp@%0d gate_lo %0d rdy_hi %0d extra %0d want rsp@11 0 0 0", t_rsp, gate_lo, rdy_hi, obs_iss.size()); end
    ec = exp_cnt.pop_front();
    n_checks++;
    if (cnt_after !== ec || gate_after !== 1'b0) begin n_fail++; $display("FAIL drain_after: cnt %0d gate %b want %0d 0", cnt_after, gate_after, ec); end
  endtask
  task automatic test_sequential();
    logic [NC-1:0] e, o;
    int t, te;
    int et[$];
    logic [1:0] ec;
    et = '{2, 6};
    run_main(2'b11, 0, 2'b00, 0, 3, 2'b00);
    while (exp_iss.size() > 0) begin
      e = exp_iss.pop_front(); te = et.pop_front(); o = 'x; t = -1;
      if (obs_iss.size() > 0) begin o = obs_iss.pop_front(); t = t_iss.pop_front(); end
      n_checks++;
      if (o !== e || t != te) begin n_fail++; $display("FAIL seq_issue: got %b at %0d want %b at %0d", o, t, e, te); end
    end
    ec = exp_cnt.pop_front();
    n_checks++;
    if (t_rsp != 10 || obs_iss.size() != 0 || cnt_after !== ec)
      begin n_fail++; $display("FAIL seq_rsp: rsp@%0d extra %0d cnt %0d want rsp@10 0 cnt %0d", t_rsp, obs_iss.size(), cnt_after, ec); end
  endtask
  task automatic test_boundary();
    logic [NC-1:0] masks[3] = '{2'b00, 2'b11, 2'b01};
    logic [NC-1:0] strays[3] = '{2'b00, 2'b00, 2'b10};
    int lags[3] = '{1, 0, 2};
    int rsps[3] = '{2, 6, 5};
    logic [NC-1:0] e, o;
    int t, te;
    logic [1:0] ec;
    for (int k = 0; k < 3; k++) begin
      run_main(masks[k], 0, 2'b00, 0, lags[k], strays[k]);
      te = 2;
      while (exp_iss.size() > 0) begin
        e = exp_iss.pop_front(); o = 'x; t = -1;
        if (obs_iss.size() > 0) begin o = obs_iss.pop_front(); t = t_iss.pop_front(); end
        n_checks++;
        if (o !== e || t != te) begin n_fail++; $display("FAIL boundary%0d_issue: got %b at %0d want %b at %0d", k, o, t, e, te); end
        te = te + 2;
      end
      ec = exp_cnt.pop_front();
      n_checks++;
      if (t_rsp != rsps[k] || obs_iss.size() != 0 || gate_lo != 0 || cnt_after !== ec)
        begin n_fail++; $display("FAIL boundary%0d_rsp: rsp@%0d extra %0d gate_lo %0d cnt %0d want rsp@%0d 0 0 cnt %0d", k, t_rsp, obs_iss.size(), gate_lo, cnt_after, rsps[k], ec); end
    end
  endtask
  task automatic test_backpressure();
    logic [NC-1:0] e, o;
    int t;
    logic [1:0] ec;
    run_main(2'b10, 0, 2'b00, 4, 1, 2'b00);
    while (exp_iss.size() > 0) begin
      e = exp_iss.pop_front(); o = 'x; t = -1;
      if (obs_iss.size() > 0) begin o = obs_iss.pop_front(); t = t_iss.pop_front(); end
      n_checks++;
      if (o !== e || t != 2) begin n_fail++; $display("FAIL bp_issue: got %b at %0d want %b at 2", o, t, e); end
    end
    n_checks++;
    if (t_rsp != 4 || rsp_cycles != 5 || gate_lo != 0 || rdy_hi != 0)
      begin n_fail++; $display("FAIL bp_hold: rsp@%0d x%0d gate_lo %0d rdy_hi %0d want rsp@4 x5 0 0", t_rsp, rsp_cycles, gate_lo, rdy_hi); end
    ec = exp_cnt.pop_front();
    n_checks++;
    if (cnt_after !== ec || gate_after !== 1'b0 || rdy_after !== 1'b1)
      begin n_fail++; $display("FAIL bp_after: cnt %0d gate %b rdy %b want %0d 0 1", cnt_after, gate_after, rdy_after, ec); end
  endtask
  task automatic test_parallel();
    logic [NC-1:0] exp_v[$];
    logic [NC-1:0] ev;
    logic er;
    int c;
    exp_v = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 20 && !p_req_ready; i++) step();
    p_req_valid = 1'b1; p_mask = 2'b11; p_c_ready = 2'b01;
    step();
    p_req_valid = 1'b0; p_mask = 2'b00;
    c = 1;
    while (exp_v.size() > 0) begin
      p_c_ready = c >= 5 ? 2'b11 : 2'b01;
      p_c_done = c == 3 ? 2'b01 : c == 7 ? 2'b10 : 2'b00;
      ev = exp_v.pop_front();
      er = c == 8;
      n_checks++;
      if (p_cfv !== ev || p_rsp_valid !== er || p_gate !== 1'b1 || p_busy !== 1'b1)
        begin n_fail++; $display("FAIL par_cycle%0d: cfv %b rsp %b gate %b busy %b want cfv %b rsp %b gate 1 busy 1", c, p_cfv, p_rsp_valid, p_gate, p_busy, ev, er); end
      step();
      c++;
    end
    p_c_done = 2'b00;
    n_checks++;
    if (p_cnt !== 16'd1 || p_gate !== 1'b0 || p_req_ready !== 1'b1)
      begin n_fail++; $display("FAIL par_after: cnt %0d gate %b rdy %b want 1 0 1", p_cnt, p_gate, p_req_ready); end
  endtask
  task automatic test_reset_mid();
    int rsp_seen;
    lag = 3; pend = '0; rsp_ready = 1'b1; man_done = '0; rsp_seen = 0;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    req_valid = 1'b1; mask = 2'b01;
    step();
    req_valid = 1'b0;
    step(); step();
    n_checks++;
    if (busy !== 1'b1 || gate !== 1'b1 || cfv !== 2'b00) begin n_fail++; $display("FAIL rmid_wait: busy %b gate %b cfv %b want 1 1 00", busy, gate, cfv); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || gate !== 1'b0 || rsp_valid !== 1'b0 || cfv !== 2'b00 || cnt !== 2'd0)
      begin n_fail++; $display("FAIL rmid_state: rdy=%b busy=%b gate=%b rsp=%b cfv=%b cnt=%0d want all zero", req_ready, busy, gate, rsp_valid, cfv, cnt); end
    for (int i = 0; i < 3; i++) begin step(); if (rsp_valid || gate) rsp_seen++; end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin if (rsp_valid || gate) rsp_seen++; if (i == 0) begin n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_early: got %b want 0", req_ready); end end step(); end
    n_checks++;
    if (rsp_seen != 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release: rsp/gate cycles %0d rdy %b want 0 1", rsp_seen, req_ready); end
    model_cnt = 2'd0;
    exp_cnt.delete(); exp_iss.delete();
  endtask
  task automatic test_wrap();
    logic [1:0] ec;
    logic [NC-1:0] e;
    for (int k = 0; k < 5; k++) begin
      run_main(2'b01, 0, 2'b00, 0, 1, 2'b00);
      while (exp_iss.size() > 0) e = exp_iss.pop_front();
      ec = exp_cnt.pop_front();
      n_checks++;
      if (cnt_after !== ec || t_rsp != 4 || obs_iss.size() != 1)
        begin n_fail++; $display("FAIL wrap%0d: cnt %0d rsp@%0d issues %0d want cnt %0d rsp@4 issues 1 (%b)", k, cnt_after, t_rsp, obs_iss.size(), ec, e); end
    end
    n_checks++;
    if (cnt !== 2'd1) begin n_fail++; $display("FAIL wrap_final: cnt %0d want 1", cnt); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_sequential();
    test_boundary();
    test_backpressure();
    test_parallel();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_cache_flush_ctrl.md
# vx_cache_flush_ctrl

Flush sequencer for a cache cluster. Accepts one flush command at a time and gates the core-side arbiter inputs. It drains in-flight core requests, then issues flush starts to a selected subset of cache units, either one at a time or all together. It waits for every selected unit to report completion, then returns a single flush response. It sits between the core/DCR flush source and the per-unit cache flush ports, beside the core request arbiters that it gates.

## Interface
- NUM_CACHES, 2: number of cache units sequenced (≥1).
- NUM_INPUTS, 2: number of core request inputs monitored for in-flight traffic (≥1).
- PARALLEL, 0: 0 issues units sequentially, lowest index first; 1 issues all selected units concurrently.
- CNT_WIDTH, 16: width of the completed-flush counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush_req_valid  in  1  flush command valid.
- flush_req_ready  out  1  flush command ready.
- flush_req_mask  in  NUM_CACHES  units to flush, sampled on accept.
- flush_rsp_valid  out  1  flush complete.
- flush_rsp_ready  in  1  response accepted.
- core_req_pending  in  NUM_INPUTS  per-input "has in-flight request" flags.
- core_gate  out  1  1 = arbiters must block new core requests.
- cache_flush_valid  out  NUM_CACHES  per-unit flush start request.
- cache_flush_ready  in  NUM_CACHES  per-unit flush start accept.
- cache_flush_done  in  NUM_CACHES  per-unit one-cycle completion pulse.
- busy  out  1  state ≠ IDLE.
- flush_count  out  CNT_WIDTH  number of completed flush responses.

## Operation
- State machine: IDLE, DRAIN, ISSUE, WAIT, RESP.
- Registers:
  - issue_pend[NUM_CACHES]: units not yet started.
  - wait_pend[NUM_CACHES]: units started but not done.
- IDLE:
  - flush_req_ready = 1.
  - On valid&ready: issue_pend ← mask, wait_pend ← 0, core_gate ← 1, go to DRAIN.
- DRAIN:
  - Go to ISSUE when core_req_pending == 0 in a cycle.
  - If issue_pend == 0 (empty mask), go to RESP instead, skipping ISSUE and WAIT.
- ISSUE, PARALLEL=1:
  - cache_flush_valid = issue_pend.
  - Each bit with valid&ready moves from issue_pend to wait_pend.
  - When issue_pend becomes 0, go to WAIT.
- ISSUE, PARALLEL=0:
  - cache_flush_valid = one-hot of the lowest set bit of issue_pend.
  - On handshake, move that bit to wait_pend and go to WAIT.
- WAIT:
  - A done pulse clears the matching wait_pend bit.
  - When wait_pend becomes 0: go to ISSUE if issue_pend ≠ 0, else go to RESP.
- Done pulse timing:
  - A done pulse is honoured if its unit's wait_pend bit is set, or if that unit's start handshake happens in the same cycle; in that case the bit never sets.
  - Done pulses for any other unit are ignored.
- RESP:
  - flush_rsp_valid = 1, core_gate stays 1.
  - On flush_rsp_ready: flush_count += 1 (wraps modulo 2^CNT_WIDTH), core_gate ← 0, go to IDLE.
- core_gate is registered. It is 1 from the cycle after accept through the cycle of the response handshake inclusive, and 0 in the cycle after.
- cache_flush_valid is driven only in ISSUE; it is 0 in all other states.

## Timing
- Reset asserted (asynchronous, immediate):
  - state = IDLE, all pend registers = 0, flush_count = 0.
  - core_gate = 0, busy = 0, flush_rsp_valid = 0, cache_flush_valid = 0.
  - flush_req_ready = 0.
- flush_req_ready stays 0 until the first clk edge after reset deasserts, then follows state == IDLE.
- Reset mid-flush: all in-flight state is abandoned, no response is produced, and core_gate drops immediately.
- Minimum latency, single unit, no pending traffic, ready=1, done one cycle after start:
  - t0: command accepted.
  - t1: DRAIN.
  - t2: ISSUE handshake.
  - t3: WAIT, done pulse.
  - t4: flush_rsp_valid = 1.
- No new command is accepted until the cycle after the response handshake (no back-to-back overlap).
- flush_rsp_valid holds until ready; the flush_req_mask value is ignored outside IDLE.

## Test plan
- **Basic.** mask=01, pending=0, cache ready=1, done at t3 → cache_flush_valid=01 at t2, flush_rsp_valid at t4, flush_count=1 after the handshake, core_gate=0 at t5.
- **Drain.** mask=11, core_req_pending=10 held 5 cycles after accept → no cache_flush_valid during those 5 cycles; ISSUE starts the cycle after pending goes to 00; core_gate stays 1 throughout.
- **Sequential vs parallel.** mask=11, PARALLEL=0 → unit1 valid only after unit0's done; with PARALLEL=1, both valid together, unit1 ready delayed 3 cycles → response only after both dones.
- **Boundary.** Empty mask → RESP at t2 with no cache_flush_valid. Done in the same cycle as the start handshake → honoured. Stray done for an unselected unit → ignored.
- **Backpressure and wrap.** flush_rsp_ready=0 for 4 cycles → valid and core_gate held, flush_req_ready=0. With CNT_WIDTH=2, 5 flushes → flush_count = 1.
- **Reset.** Reset asserted during WAIT → outputs go to reset values immediately, no response. After release: flush_req_ready=1 at the first edge, and a new flush completes normally.
